// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC stage: FSM states, default Q format and the
// rescale-and-saturate helper used on the final accumulator value.
package neuron_pkg;

    typedef enum logic [1:0] {
        StPrime,
        StAccum,
        StBias,
        StOut
    } state_e;

    localparam int DefWordSize = 8;
    localparam int DefFracBits = 4;

    // Arithmetic right shift by frac, then clamp to a signed range of the given width.
    function automatic logic signed [63:0] sat_trunc(
        input logic signed [63:0] value,
        input int                 frac,
        input int                 width
    );
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        shifted = value >>> frac;
        max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (width - 1));
        if (shifted > max_v) begin
            return max_v;
        end else if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Bundle of the activation input stream, weight ROM port and activation output stream.
// slave is the neuron stage's view; master is the driving environment's view.
interface neuron_mac_seq_if
    import neuron_pkg::*;
#(
    parameter int WORD_SIZE  = DefWordSize,
    parameter int ADDR_WIDTH = 3
);
    logic signed [WORD_SIZE-1:0] data_i;
    logic                        valid_i;
    logic                        ready_o;
    logic        [ADDR_WIDTH-1:0] rom_addr_o;
    logic signed [WORD_SIZE-1:0] rom_data_i;
    logic signed [WORD_SIZE-1:0] data_o;
    logic                        valid_o;
    logic                        ready_i;

    modport slave (
        input  data_i, valid_i, rom_data_i, ready_i,
        output ready_o, rom_addr_o, data_o, valid_o
    );

    modport master (
        output data_i, valid_i, rom_data_i, ready_i,
        input  ready_o, rom_addr_o, data_o, valid_o
    );

endinterface

// File: rtl/neuron_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and enable. acc_final_o adds the
// bias (taken from the same ROM data bus) aligned to the accumulator's Q format.
module neuron_mac_unit #(
    parameter int WORD_SIZE = 8,
    parameter int FRAC_BITS = 4,
    parameter int ACC_W     = 19
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        clr_i,
    input  logic                        en_i,
    input  logic signed [WORD_SIZE-1:0] act_i,
    input  logic signed [WORD_SIZE-1:0] rom_data_i,
    output logic signed [ACC_W-1:0]     acc_final_o
);
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic signed [2*WORD_SIZE-1:0] prod;

    // Product and next accumulator value; clear wins over enable.
    always_comb begin
        prod  = act_i * rom_data_i;
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Bias is an integer-aligned word, so shift it up into the product's Q format.
    always_comb begin
        acc_final_o = acc_q + (ACC_W'(rom_data_i) <<< FRAC_BITS);
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Neuron datapath stage: sequences the weight ROM so one weight lines up with each
// accepted activation, accumulates, adds bias, rescales, saturates and presents one
// result per inference on a valid/ready handshake.
// Build option: define NEURON_RELU_EN to clamp negative results to zero.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int INPUT_SIZE = 4,
    parameter int WORD_SIZE  = DefWordSize,
    parameter int FRAC_BITS  = DefFracBits,
    parameter int ADDR_WIDTH = 3
) (
    input  logic            clk_i,
    input  logic            reset_i,
    neuron_mac_seq_if.slave bus_if
);
    localparam int CNT_W = $clog2(INPUT_SIZE + 1);
    localparam int ACC_W = 2 * WORD_SIZE + CNT_W;
    localparam logic [CNT_W-1:0]      LastCnt  = CNT_W'(INPUT_SIZE - 1);

    state_e                      state_q, state_d;
    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [WORD_SIZE-1:0] data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        accept;
    logic                        mac_clr;
    logic                        mac_en;
    logic                        ready;
    logic        [ADDR_WIDTH-1:0] rom_addr;
    logic signed [ACC_W-1:0]     acc_final;
    logic signed [WORD_SIZE-1:0] result;

    neuron_mac_unit #(
        .WORD_SIZE (WORD_SIZE),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clr_i       (mac_clr),
        .en_i        (mac_en),
        .act_i       (bus_if.data_i),
        .rom_data_i  (bus_if.rom_data_i),
        .acc_final_o (acc_final)
    );

    // Rescale and saturate the biased sum; optionally rectify.
    always_comb begin
        result = WORD_SIZE'(sat_trunc(64'(acc_final), FRAC_BITS, WORD_SIZE));
`ifdef NEURON_RELU_EN
        if (result[WORD_SIZE-1]) begin
            result = '0;
        end
`endif
    end

    // Next state, counter, ROM address and handshake outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ready    = 1'b0;
        accept   = 1'b0;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        rom_addr = '0;
        unique case (state_q)
            StPrime: begin
                state_d = StAccum;
            end
            StAccum: begin
                ready  = 1'b1;
                accept = bus_if.valid_i;
                // Look one address ahead on accept so rom_data_i tracks weight[cnt_q].
                if (accept) begin
                    mac_en   = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    rom_addr = ADDR_WIDTH'(cnt_q + CNT_W'(1));
                    if (cnt_q == LastCnt) begin
                        state_d = StBias;
                    end
                end else begin
                    rom_addr = ADDR_WIDTH'(cnt_q);
                end
            end
            StBias: begin
                data_d  = result;
                valid_d = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                // Address 0 is fetched here so the next inference needs no prime cycle.
                if (bus_if.ready_i) begin
                    valid_d = 1'b0;
                    mac_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = StAccum;
                end
            end
            default: begin
                state_d = StPrime;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StPrime;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus_if.ready_o    = ready;
    assign bus_if.rom_addr_o = rom_addr;
    assign bus_if.data_o     = data_q;
    assign bus_if.valid_o    = valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Randomized and directed bench for neuron_mac_seq with a weight ROM model and an
// arithmetic reference model of one inference.
module tb_neuron_mac_seq;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int F  = 4;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   ready_mode = 0;  // 0: ready_i=1, 1: ready_i=0, 2: random

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_mac_seq_if #(.WORD_SIZE(W), .ADDR_WIDTH(AW)) bus_if ();

    neuron_mac_seq #(
        .INPUT_SIZE (N),
        .WORD_SIZE  (W),
        .FRAC_BITS  (F),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_if  (bus_if)
    );

    // Weight ROM with one-cycle registered read.
    logic signed [W-1:0] rom_mem [8];
    always @(posedge clk) bus_if.rom_data_i <= rom_mem[bus_if.rom_addr_o];

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus_if.ready_i = 1'b1;
            1:       bus_if.ready_i = 1'b0;
            default: bus_if.ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] expd);
        checks++;
        if (got !== expd) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, expd, $time);
        end
    endtask

    // One inference: dot product plus bias in Q(F), floor-shifted, clamped to W bits.
    function automatic int model_out(input int xs[$]);
        longint acc = 0;
        for (int i = 0; i < N; i++) acc += longint'(xs[i]) * longint'(rom_mem[i]);
        acc += longint'(rom_mem[N]) * (longint'(1) << F);
        acc = acc >>> F;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
`ifdef NEURON_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return int'(acc);
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle.
    int  vec[$];
    int  exp_q[$];
    int  out_cyc[$];
    int  complete_cyc = -100;
    bit  hold_pending = 0;
    bit  prev_valid = 0;
    logic signed [W-1:0] held;

    always @(negedge clk) begin
        if (reset) begin
            vec.delete();
            exp_q.delete();
            hold_pending = 0;
            prev_valid   = 0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(bus_if.valid_o), 1);
                check("hold_data", $signed(bus_if.data_o), held);
            end
            if (bus_if.valid_o && !prev_valid) check("latency", cyc - complete_cyc, 2);
            if (bus_if.valid_o) check("ready_in_out", 32'(bus_if.ready_o), 0);
            if (bus_if.ready_o && bus_if.valid_i) begin
                check("rom_addr_accept", 32'(bus_if.rom_addr_o), vec.size() + 1);
                vec.push_back(int'($signed(bus_if.data_i)));
                if (vec.size() == N) begin
                    exp_q.push_back(model_out(vec));
                    complete_cyc = cyc;
                    vec.delete();
                end
            end else if (bus_if.ready_o) begin
                check("rom_addr_idle", 32'(bus_if.rom_addr_o), vec.size());
            end
            if (bus_if.valid_o && bus_if.ready_i) begin
                check("output_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("data_o", $signed(bus_if.data_o), exp_q.pop_front());
                out_cyc.push_back(cyc);
            end
            hold_pending = bus_if.valid_o && !bus_if.ready_i;
            held         = bus_if.data_o;
            prev_valid   = bus_if.valid_o;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus_if.valid_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_valid_o", 32'(bus_if.valid_o), 0);
        check("rst_ready_o", 32'(bus_if.ready_o), 0);
        check("rst_rom_addr", 32'(bus_if.rom_addr_o), 0);
        check("rst_data_o", $signed(bus_if.data_o), 0);
    endtask

    task automatic set_rom(input int w0, input int w1, input int w2, input int w3,
                           input int b);
        rom_mem[0] = W'(w0);
        rom_mem[1] = W'(w1);
        rom_mem[2] = W'(w2);
        rom_mem[3] = W'(w3);
        rom_mem[4] = W'(b);
        bus_if.valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_one(input int x);
        bit done = 0;
        bus_if.data_i  = W'(x);
        bus_if.valid_i = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (bus_if.ready_o) done = 1;
        end
        check("accept_in_time", 32'(done), 1);
        @(posedge clk); #1;
        bus_if.valid_i = 1'b0;
    endtask

    task automatic send_gap(input int x, input int gap);
        repeat (gap) begin
            bus_if.valid_i = 1'b0;
            @(posedge clk); #1;
        end
        send_one(x);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || bus_if.valid_o) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", 32'(exp_q.size() == 0 && !bus_if.valid_o), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        bus_if.valid_i = 1'b0;
        bus_if.data_i  = '0;
        for (int i = 0; i < 8; i++) rom_mem[i] = '0;
        set_rom(16, 16, 16, 16, 8);
        do_reset();

        // Nominal
        for (int i = 0; i < N; i++) send_one(16);
        wait_idle();

        // Positive and negative saturation
        set_rom(127, 127, 127, 127, 0);
        for (int i = 0; i < N; i++) send_one(127);
        wait_idle();
        for (int i = 0; i < N; i++) send_one(-128);
        wait_idle();

        // Negative sum (rectified when ReLU is built in)
        set_rom(-16, -16, -16, -16, 0);
        for (int i = 0; i < N; i++) send_one(16);
        wait_idle();

        // Input gaps plus output backpressure
        set_rom(16, 16, 16, 16, 8);
        ready_mode = 1;
        send_gap(16, 0);
        send_gap(16, 2);
        send_gap(16, 0);
        send_gap(16, 1);
        for (int t = 0; t < 20 && !bus_if.valid_o; t++) @(negedge clk);
        check("bp_valid_seen", 32'(bus_if.valid_o), 1);
        repeat (5) @(negedge clk);
        ready_mode = 0;
        wait_idle();

        // Reset in the middle of accumulation
        send_one(16);
        send_one(16);
        do_reset();
        for (int i = 0; i < N; i++) send_one(16);
        wait_idle();

        // Back-to-back inferences
        out_cyc.delete();
        for (int v = 0; v < 3; v++) for (int i = 0; i < N; i++) send_one(16);
        wait_idle();
        check("b2b_count", out_cyc.size(), 3);
        if (out_cyc.size() == 3) begin
            check("b2b_gap1", out_cyc[1] - out_cyc[0], N + 2);
            check("b2b_gap2", out_cyc[2] - out_cyc[1], N + 2);
        end

        // Randomized inferences with random gaps, backpressure and occasional resets
        ready_mode = 2;
        for (int it = 0; it < 25; it++) begin
            set_rom($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                    $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                    $urandom_range(0, 255) - 128);
            if ($urandom_range(0, 5) == 0) begin
                int k = $urandom_range(1, N - 1);
                for (int i = 0; i < k; i++) send_one($urandom_range(0, 255) - 128);
                do_reset();
            end
            for (int i = 0; i < N; i++)
                send_gap($urandom_range(0, 255) - 128, $urandom_range(0, 2));
            wait_idle();
        end
        ready_mode = 0;

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Neuron datapath stage directly downstream of the per-neuron weight ROM.
- Sequences the ROM address so that exactly one stored weight lines up with each accepted input activation.
- Multiply-accumulates signed fixed-point values over INPUT_SIZE inputs, adds the stored bias, rescales, saturates and applies an optional ReLU.
- Emits one activation per inference on a valid/ready output handshake.

Parameters:
- INPUT_SIZE, 4: number of inputs and weights per inference (N).
- WORD_SIZE, 8: signed width of activations, weights and bias.
- FRAC_BITS, 4: fractional bits of the shared Q format.
- ADDR_WIDTH, 3: ROM address width; must satisfy 2**ADDR_WIDTH >= N+1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- data_i  in  WORD_SIZE  signed input activation.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block accepts data_i this cycle.
- rom_addr_o  out  ADDR_WIDTH  address to the weight ROM (ROM has 1-cycle registered read).
- rom_data_i  in  WORD_SIZE  ROM read data for the address presented on the previous edge.
- data_o  out  WORD_SIZE  signed output activation.
- valid_o  out  1  data_o valid.
- ready_i  in  1  downstream accepts data_o.

Behaviour:
- Single clock clk_i; reset_i is synchronous and active-high.
- ROM layout: weights at addresses 0..N-1; bias at address N.
- Internal widths: localparam ACC_W = 2*WORD_SIZE + $clog2(N+1); count is a registered counter, 0..N.
- States:
  - PRIME: one cycle; rom_addr_o=0; then goes to ACCUM.
  - ACCUM:
    - ready_o=1.
    - Accept when valid_i && ready_o: acc += sext(data_i) * rom_data_i, and count++.
    - rom_addr_o = accept ? count+1 : count, combinational, so rom_data_i always equals weight[count].
    - The accept with count==N-1 moves to BIAS, with rom_addr_o=N.
  - BIAS:
    - One cycle; ready_o=0.
    - acc_final = acc + (sext(rom_data_i) <<< FRAC_BITS).
    - result = acc_final >>> FRAC_BITS (arithmetic); saturate to [-2**(W-1), 2**(W-1)-1]; apply ReLU if enabled.
    - Register result into data_o; set valid_o=1; go to OUT.
  - OUT:
    - valid_o=1, ready_o=0, rom_addr_o=0.
    - data_o is held stable while ready_i=0.
    - On ready_i=1: valid_o=0, acc=0, count=0; go to ACCUM. No PRIME is needed, because weight[0] was already fetched during OUT.
- Latency: last input accepted at cycle t gives valid_o=1 at t+2.
- Throughput: one input per cycle while valid_i stays high; N+2 cycles minimum per inference when ready_i=1.
- Gaps: a valid_i gap stalls accumulation; count and acc hold.
- Reset: state=PRIME, acc=0, count=0, data_o=0, valid_o=0, ready_o=0, rom_addr_o=0.
- Reset mid-operation: a reset during any state discards the partial sum. The first output after reset reflects only inputs accepted after reset.
- Simultaneous events: reset dominates valid_i and ready_i.

Optional Feature:
- Macro NEURON_RELU_EN.
- Defined: negative saturated results are forced to 0 before registering data_o.
- Undefined: the signed saturated result passes through unchanged (final/output layer use).

Decomposition:
- Package neuron_pkg holds:
  - the state enum (PRIME, ACCUM, BIAS, OUT);
  - the default WORD_SIZE/FRAC_BITS constants;
  - a sat_trunc function (arithmetic shift plus signed saturation).
- One natural sub-module: neuron_mac_unit. It is the signed multiply-accumulate with clear and enable, plus bias alignment. The FSM, counter and address logic remain in the top level.

Test Plan (N=4, W=8, F=4):
- Nominal: weights 16,16,16,16, bias 8; inputs 16 x4 back-to-back, ready_i=1 -> data_o=72 (4.5), valid_o 2 cycles after the 4th accept; rom_addr_o sequence 1,2,3,4.
- Saturation: weights 127 x4, bias 0, inputs 127 x4 -> data_o=127. Inputs -128 with weights 127, ReLU off -> data_o=-128.
- ReLU: weights -16 x4, bias 0, inputs 16 x4 -> data_o=0 with NEURON_RELU_EN; data_o=0xC0 (-64) without.
- Backpressure and gaps: valid_i pattern 1,0,0,1,1,0,1; then ready_i=0 for 5 cycles -> result identical to the nominal case; data_o and valid_o stable while ready_i=0; ready_o=0 throughout OUT; the next inference starts in ACCUM with no PRIME cycle.
- Reset mid-ACCUM: 2 inputs accepted, then reset_i for 1 cycle, then the nominal 4-input stream -> data_o=72. valid_o=0, ready_o=0 and rom_addr_o=0 in the cycle after reset.
- Back-to-back inferences: 3 consecutive nominal vectors with ready_i=1 -> 3 outputs of 72, each exactly N+2 cycles apart.
